// File: rtl/vita_rx_pkt_buffer_pkg.sv
// Types and constants for the VITA rx packet buffer; line layout comes from vita_rx_defs.vh.
`include "vita_rx_defs.vh"
package vita_rx_pkt_buffer_pkg;
  localparam int LINE_W  = 36;
  localparam int SOF_BIT = `VITA_SOF_BIT;
  localparam int EOF_BIT = `VITA_EOF_BIT;

  typedef enum logic [1:0] {
    W_IDLE = `VITA_W_IDLE,
    W_PKT  = `VITA_W_PKT,
    W_DROP = `VITA_W_DROP
  } wr_state_t;
endpackage

// File: rtl/ram_2port.sv
// Simple dual-port RAM: synchronous write on port A, registered read on port B.
// One-cycle read latency; a read of an address written on the same edge returns the old word.
module ram_2port #(
  parameter int DWIDTH = 36,
  parameter int AWIDTH = 9
) (
  input  logic              clka,
  input  logic              ena,
  input  logic              wea,
  input  logic [AWIDTH-1:0] addra,
  input  logic [DWIDTH-1:0] dia,
  input  logic              clkb,
  input  logic              enb,
  input  logic [AWIDTH-1:0] addrb,
  output logic [DWIDTH-1:0] dob
);
  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  always_ff @(posedge clka) begin
    if (ena && wea) mem[addra] <= dia;
  end

  always_ff @(posedge clkb) begin
    if (enb) dob <= mem[addrb];
  end
endmodule

// File: rtl/vita_rx_defs.vh
// Line-format bit positions and write-FSM state codes shared by the VITA rx path.
`ifndef VITA_RX_DEFS_VH
`define VITA_RX_DEFS_VH
`define VITA_SOF_BIT 32
`define VITA_EOF_BIT 33
`define VITA_OCC_MSB 35
`define VITA_OCC_LSB 34
`define VITA_W_IDLE 2'd0
`define VITA_W_PKT  2'd1
`define VITA_W_DROP 2'd2
`endif

// File: rtl/vita_rx_pkt_buffer.sv
// Store-and-forward buffer: a packet is released 2 cycles after its EOF is written; oversize/truncated packets are dropped whole.
// Input is never stalled out of reset; output holds data_o stable under dst_rdy_i=0 and streams bubble-free when ready.
module vita_rx_pkt_buffer
  import vita_rx_pkt_buffer_pkg::*;
#(
  parameter int BUF_AW = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [LINE_W-1:0] data_i,
  input  logic              src_rdy_i,
  output logic              dst_rdy_o,
  output logic [LINE_W-1:0] data_o,
  output logic              src_rdy_o,
  input  logic              dst_rdy_i,
  output logic [BUF_AW:0]   pkt_count,
  output logic [BUF_AW:0]   occupied,
  output logic [CNT_W-1:0]  drop_count,
  output logic              drop_o
);
  typedef logic [BUF_AW-1:0] ptr_t;
  localparam ptr_t            PTR_ONE = ptr_t'(1);
  localparam logic [BUF_AW:0] CNT_ONE = (BUF_AW+1)'(1);

  wr_state_t         state, state_n;
  ptr_t              wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, rd_ptr, rd_ptr_n, base_ptr;
  logic              in_xfer, in_sof, in_eof, full, wr_en, commit_evt;
  logic [1:0]        drop_inc;
  logic              rd_vld, load, out_xfer, out_eof;
  logic [LINE_W-1:0] ram_dat;
  logic [CNT_W:0]    drop_sum;

  assign dst_rdy_o = reset;
  assign in_xfer   = src_rdy_i & dst_rdy_o & ~clear;
  assign in_sof    = data_i[SOF_BIT];
  assign in_eof    = data_i[EOF_BIT];

  // A SOF always restarts at the last commit point, abandoning any open packet.
  assign base_ptr = in_sof ? commit_ptr : wr_ptr;
  assign full     = (ptr_t'(base_ptr + PTR_ONE) == rd_ptr);

  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    wr_en        = 1'b0;
    commit_evt   = 1'b0;
    drop_inc     = 2'd0;
    if (in_xfer && (in_sof || state == W_PKT)) begin
      if (in_sof && state == W_PKT) drop_inc = 2'd1;
      if (full) begin
        drop_inc = drop_inc + 2'd1;
        wr_ptr_n = commit_ptr;
        state_n  = in_eof ? W_IDLE : W_DROP;
      end else begin
        wr_en    = 1'b1;
        wr_ptr_n = base_ptr + PTR_ONE;
        state_n  = W_PKT;
        if (in_eof) begin
          commit_ptr_n = base_ptr + PTR_ONE;
          commit_evt   = 1'b1;
          state_n      = W_IDLE;
        end
      end
    end else if (in_xfer && state == W_DROP && in_eof) begin
      state_n = W_IDLE;
    end
  end

  // The RAM is always reading the line at rd_ptr_n, so ram_dat mirrors the head of the committed data.
  assign out_xfer = src_rdy_o & dst_rdy_i;
  assign load     = rd_vld & (~src_rdy_o | dst_rdy_i);
  assign rd_ptr_n = load ? ptr_t'(rd_ptr + PTR_ONE) : rd_ptr;
  assign out_eof  = data_o[EOF_BIT];

  ram_2port #(
    .DWIDTH(LINE_W),
    .AWIDTH(BUF_AW)
  ) u_ram (
    .clka  (clk),
    .ena   (1'b1),
    .wea   (wr_en),
    .addra (base_ptr),
    .dia   (data_i),
    .clkb  (clk),
    .enb   (1'b1),
    .addrb (rd_ptr_n),
    .dob   (ram_dat)
  );

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      state      <= W_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      rd_vld     <= 1'b0;
      src_rdy_o  <= 1'b0;
      data_o     <= '0;
      pkt_count  <= '0;
      drop_o     <= 1'b0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      rd_ptr     <= rd_ptr_n;
      // Compared against the pre-edge commit_ptr so the RAM read has already seen the write.
      rd_vld     <= (rd_ptr_n != commit_ptr);
      drop_o     <= (drop_inc != 2'd0);
      if (load) begin
        data_o    <= ram_dat;
        src_rdy_o <= 1'b1;
      end else if (out_xfer) begin
        src_rdy_o <= 1'b0;
      end
      case ({commit_evt, out_xfer & out_eof})
        2'b10:   pkt_count <= pkt_count + CNT_ONE;
        2'b01:   pkt_count <= pkt_count - CNT_ONE;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  assign drop_sum = {1'b0, drop_count} + {{(CNT_W-1){1'b0}}, drop_inc};

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (drop_inc != 2'd0) begin
      drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

  assign occupied = {1'b0, ptr_t'(wr_ptr - rd_ptr)} + {{BUF_AW{1'b0}}, src_rdy_o};
endmodule

// File: tb/tb_vita_rx_pkt_buffer.sv
// Bench for vita_rx_pkt_buffer: directed corner sequences, a packet table, and randomized packets against a packet-level model.
module tb_vita_rx_pkt_buffer;
  localparam int AW  = 4;
  localparam int CW  = 16;
  localparam int CAP = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic [35:0]   data_i = '0;
  logic          src_rdy_i = 1'b0;
  logic          dst_rdy_o;
  logic [35:0]   data_o;
  logic          src_rdy_o;
  logic          dst_rdy_i = 1'b0;
  logic [AW:0]   pkt_count;
  logic [AW:0]   occupied;
  logic [CW-1:0] drop_count;
  logic          drop_o;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 stalled
  int out_lines = 0;
  int drop_pulses = 0;
  int exp_drops = 0;
  logic [35:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [35:0] prev_dat = '0;

  typedef struct {
    int len;
    bit trunc;
    int exp_lines;
    int exp_drop;
  } vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;

  vita_rx_pkt_buffer #(.BUF_AW(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .data_i     (data_i),
    .src_rdy_i  (src_rdy_i),
    .dst_rdy_o  (dst_rdy_o),
    .data_o     (data_o),
    .src_rdy_o  (src_rdy_o),
    .dst_rdy_i  (dst_rdy_i),
    .pkt_count  (pkt_count),
    .occupied   (occupied),
    .drop_count (drop_count),
    .drop_o     (drop_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: every handshake must match the head of the expected queue.
  initial forever begin
    @(negedge clk);
    if (reset && !clear) begin
      if (drop_o) drop_pulses++;
      if (prev_stall) check("hold_stable", {src_rdy_o, data_o}, {1'b1, prev_dat});
      if (src_rdy_o && dst_rdy_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h expected no line", data_o);
        end else begin
          check("out_line", data_o, exp_q.pop_front());
        end
        out_lines++;
      end
      prev_stall = src_rdy_o && !dst_rdy_i;
      prev_dat   = data_o;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    dst_rdy_i = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [35:0] mk(input bit sof, input bit eof, input logic [31:0] pl);
    return {2'($urandom_range(0, 3)), eof, sof, pl};
  endfunction

  task automatic send_line(input logic [35:0] l, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        src_rdy_i = 1'b0;
        data_i = {$urandom, 4'h0};
        @(posedge clk);
        #1;
      end
    end
    src_rdy_i = 1'b1;
    data_i = l;
    @(posedge clk);
    #1;
    src_rdy_i = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit close, input bit push, input bit gaps);
    logic [35:0] l;
    for (int i = 0; i < len; i++) begin
      l = mk(i == 0, close && (i == len - 1), $urandom);
      if (push) exp_q.push_back(l);
      send_line(l, gaps);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pkt_count != 0 || src_rdy_o) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_drain: got %0d lines pending, pkt_count %0d, expected empty", name, exp_q.size(), pkt_count);
    end
  endtask

  initial begin
    logic [35:0] l, first;
    int base, len, kind;

    tbl[0] = '{1, 1'b0, 1, 0};
    tbl[1] = '{2, 1'b0, 2, 0};
    tbl[2] = '{CAP, 1'b0, CAP, 0};
    tbl[3] = '{CAP + 1, 1'b0, 0, 1};
    tbl[4] = '{20, 1'b0, 0, 1};
    tbl[5] = '{5, 1'b0, 5, 0};
    tbl[6] = '{3, 1'b1, 4, 1};
    tbl[7] = '{1, 1'b1, 4, 1};
    tbl[8] = '{9, 1'b0, 9, 0};

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dst_rdy", dst_rdy_o, 0);
    check("rst_src_rdy", src_rdy_o, 0);
    check("rst_data", data_o, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_occupied", occupied, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_drop_o", drop_o, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("dst_rdy_out_of_reset", dst_rdy_o, 1);

    // Framer-style 13-line packet: nothing out before EOF, first line at EOF+2
    rdy_mode = 0;
    first = '0;
    for (int i = 0; i < 13; i++) begin
      l = (i == 0) ? {2'b01, 1'b0, 1'b1, 32'h15F0000D} : mk(0, i == 12, 32'hA000_0000 + i);
      if (i == 0) first = l;
      exp_q.push_back(l);
      send_line(l, 0);
      if (i == 11) begin
        check("pre_eof_src_rdy", src_rdy_o, 0);
        check("pre_eof_pkt_count", pkt_count, 0);
      end
    end
    check("eof_edge_src_rdy", src_rdy_o, 0);
    check("eof_edge_pkt_count", pkt_count, 1);
    @(posedge clk);
    #1;
    check("eof_plus1_src_rdy", src_rdy_o, 0);
    @(posedge clk);
    #1;
    check("eof_plus2_src_rdy", src_rdy_o, 1);
    check("eof_plus2_data", data_o, first);
    base = 0;
    drain("framer");
    check("framer_lines", out_lines - base, 13);
    check("framer_pkt_count", pkt_count, 0);

    // Single SOF|EOF line
    base = out_lines;
    l = {2'b10, 1'b1, 1'b1, 32'hE000_0000};
    exp_q.push_back(l);
    send_line(l, 0);
    drain("single");
    check("single_lines", out_lines - base, 1);
    check("single_drops", drop_count, 0);

    // Packet table with random output backpressure
    rdy_mode = 1;
    for (int k = 0; k < 9; k++) begin
      base = out_lines;
      exp_drops += tbl[k].exp_drop;
      if (tbl[k].trunc) begin
        send_pkt(tbl[k].len, 0, 0, 1);
        send_pkt(4, 1, 1, 1);
      end else begin
        send_pkt(tbl[k].len, 1, tbl[k].exp_lines > 0, 1);
      end
      drain("table");
      check("table_lines", out_lines - base, tbl[k].exp_lines);
      check("table_drop_count", drop_count, exp_drops);
      check("table_drop_pulses", drop_pulses, exp_drops);
    end

    // Fill to capacity with output stalled, then overflow
    rdy_mode = 2;
    @(posedge clk);
    #1;
    base = out_lines;
    repeat (3) send_pkt(5, 1, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    check("fill_pkt_count", pkt_count, 3);
    check("fill_occupied", occupied, CAP);
    check("fill_src_rdy", src_rdy_o, 1);
    check("fill_head", data_o, exp_q[0]);
    send_pkt(5, 1, 0, 0);
    exp_drops++;
    repeat (3) @(posedge clk);
    #1;
    check("overflow_drop_count", drop_count, exp_drops);
    check("overflow_drop_pulses", drop_pulses, exp_drops);
    check("overflow_occupied", occupied, CAP);
    check("overflow_pkt_count", pkt_count, 3);
    rdy_mode = 0;
    drain("fill");
    check("fill_lines", out_lines - base, 15);
    check("fill_pkt_count_end", pkt_count, 0);

    // clear mid-packet, colliding with an EOF line; drop_count retained
    rdy_mode = 1;
    send_pkt(3, 0, 0, 0);
    data_i = mk(0, 1, $urandom);
    src_rdy_i = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    src_rdy_i = 1'b0;
    check("clear_pkt_count", pkt_count, 0);
    check("clear_occupied", occupied, 0);
    check("clear_drop_count", drop_count, exp_drops);
    base = out_lines;
    send_pkt(6, 1, 1, 1);
    drain("after_clear");
    check("after_clear_lines", out_lines - base, 6);
    check("after_clear_drops", drop_count, exp_drops);

    // Reset pulse mid-output with toggling ready
    base = out_lines;
    send_pkt(10, 1, 1, 0);
    len = 0;
    while (out_lines - base < 2 && len < 200) begin
      @(posedge clk);
      #1;
      len++;
    end
    check("midout_started", out_lines - base >= 2, 1);
    reset = 1'b0;
    #1;
    check("midout_dst_rdy", dst_rdy_o, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("midout_src_rdy", src_rdy_o, 0);
    check("midout_pkt_count", pkt_count, 0);
    check("midout_occupied", occupied, 0);
    check("midout_drop_count", drop_count, 0);
    exp_q.delete();
    exp_drops = 0;
    drop_pulses = 0;
    base = out_lines;
    send_pkt(7, 1, 1, 1);
    drain("after_reset");
    check("after_reset_lines", out_lines - base, 7);

    // Randomized packets: buffer drained between packets, so the only drops are oversize and truncation
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      if (kind == 6) begin
        len = $urandom_range(CAP + 1, CAP + 8);
      end else begin
        len = $urandom_range(1, CAP);
      end
      if (kind == 7) begin
        send_pkt($urandom_range(1, 8), 0, 0, 1);
        exp_drops++;
      end else if (kind == 8) begin
        repeat ($urandom_range(1, 3)) send_line(mk(0, 1'($urandom_range(0, 1)), $urandom), 1);
      end else if (kind == 9) begin
        len = 1;
      end
      send_pkt(len, 1, len <= CAP, 1);
      if (len > CAP) exp_drops++;
      drain("rand");
      check("rand_drop_count", drop_count, exp_drops);
      check("rand_drop_pulses", drop_pulses, exp_drops);
      check("rand_occupied", occupied, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
